// File: rtl/fg_waveform_analyzer.sv
// -----------------------------------------------------------------------------
// fg_waveform_analyzer
//
// Recovers per-period parameters from the signed sample stream produced by the
// function generator's waveform stage (or an ADC loopback of it). One result
// set is reported per complete period, marked by a single-cycle valid strobe.
//
// Ports:
//   clk_i        clock
//   rstn_i       synchronous active-low reset
//   clk_en_i     sample strobe; state and counters advance only when high
//   sample_i     signed input sample (WAVEFORM_BITWIDTH+1 bits)
//   period_o     samples per period
//   rise_len_o   samples classified RISE
//   on_len_o     samples classified ON
//   fall_len_o   samples classified FALL
//   amplitude_o  maximum sample in the period (signed)
//   k_rise_o     first rise delta of the period
//   k_fall_o     magnitude of the first fall delta of the period
//   valid_o      one-cycle pulse: result outputs were updated
//   err_o        one-cycle pulse: protocol violation or counter saturation
// -----------------------------------------------------------------------------
module fg_waveform_analyzer #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clk_en_i,
    input  logic [WAVEFORM_BITWIDTH:0]  sample_i,
    output logic [COUNTER_BITWIDTH-1:0] period_o,
    output logic [COUNTER_BITWIDTH-1:0] rise_len_o,
    output logic [COUNTER_BITWIDTH-1:0] on_len_o,
    output logic [COUNTER_BITWIDTH-1:0] fall_len_o,
    output logic [WAVEFORM_BITWIDTH:0]  amplitude_o,
    output logic [WAVEFORM_BITWIDTH:0]  k_rise_o,
    output logic [WAVEFORM_BITWIDTH:0]  k_fall_o,
    output logic                        valid_o,
    output logic                        err_o
);

    localparam int SW = WAVEFORM_BITWIDTH + 1;
    localparam int DW = WAVEFORM_BITWIDTH + 2;
    localparam int CW = COUNTER_BITWIDTH;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_IDLE = 3'd1,
        S_RISE = 3'd2,
        S_ON   = 3'd3,
        S_FALL = 3'd4
    } state_t;

    // A counter saturates when the increment about to be applied would make
    // it all-ones.
    function automatic logic hits_max(input logic [CW-1:0] cnt, input logic inc);
        return inc && ((cnt + CNT_ONE) == CNT_MAX);
    endfunction

    function automatic logic signed [SW-1:0] smax(input logic signed [SW-1:0] a,
                                                  input logic signed [SW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t state_q, state_d;

    logic signed [SW-1:0] sample_s;
    logic signed [SW-1:0] prev_q;
    logic signed [DW-1:0] sample_ext, prev_ext, delta;
    logic signed [SW-1:0] k_rise_new, k_fall_new;
    logic                 low, d_pos, d_neg, d_zero;

    logic [CW-1:0]        period_cnt_q, rise_cnt_q, on_cnt_q, fall_cnt_q;
    logic signed [SW-1:0] amp_q, k_rise_q, k_fall_q;
    logic                 kf_cap_q, armed_q;

    logic [CW-1:0]        period_out_q, rise_out_q, on_out_q, fall_out_q;
    logic signed [SW-1:0] amp_out_q, k_rise_out_q, k_fall_out_q;

    logic start, viol, sat, inc_rise, inc_on, inc_fall;
    logic err_evt, load_evt, valid_evt, count_evt;

    assign sample_s   = sample_i;
    assign sample_ext = {sample_s[SW-1], sample_s};
    assign prev_ext   = {prev_q[SW-1], prev_q};
    assign delta      = sample_ext - prev_ext;
    assign k_rise_new = SW'(delta);
    assign k_fall_new = SW'(-delta);

    assign low    = (sample_s <= 0);
    assign d_neg  = delta[DW-1];
    assign d_zero = (delta == '0);
    assign d_pos  = !d_neg && !d_zero;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_SYNC;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-sample classification
    always_comb begin : next_state
        state_d  = state_q;
        start    = 1'b0;
        viol     = 1'b0;
        inc_rise = 1'b0;
        inc_on   = 1'b0;
        inc_fall = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (low) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!low) begin
                    start   = 1'b1;
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                if (d_pos) begin
                    inc_rise = 1'b1;
                end else if (d_zero) begin
                    inc_on  = 1'b1;
                    state_d = S_ON;
                end else begin
                    inc_fall = 1'b1;
                    state_d  = S_FALL;
                end
            end
            S_ON: begin
                if (d_zero) begin
                    inc_on = 1'b1;
                end else if (d_neg) begin
                    inc_fall = 1'b1;
                    state_d  = S_FALL;
                end else begin
                    viol = 1'b1;
                end
            end
            S_FALL: begin
                if (d_pos) begin
                    // Generator re-triggered before the ramp reached zero.
                    start   = 1'b1;
                    state_d = S_RISE;
                end else if (d_neg) begin
                    inc_fall = 1'b1;
                    if (low) state_d = S_IDLE;
                end else if (low) begin
                    state_d = S_IDLE;
                end else begin
                    viol = 1'b1;
                end
            end
            default: state_d = S_SYNC;
        endcase

        // Counting only happens once armed, so SYNC never saturates.
        sat = armed_q && (hits_max(period_cnt_q, 1'b1) ||
                          hits_max(rise_cnt_q, inc_rise) ||
                          hits_max(on_cnt_q, inc_on)     ||
                          hits_max(fall_cnt_q, inc_fall));

        if (viol || sat) state_d = S_SYNC;
    end

    // FSM output decode; an error overrides a coincident start.
    always_comb begin : fsm_outputs
        err_evt   = viol || sat;
        load_evt  = start && !err_evt;
        valid_evt = load_evt && armed_q;
        count_evt = armed_q && !start && !err_evt;
    end

    // Counters, measurement registers and result outputs
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prev_q       <= '0;
            period_cnt_q <= '0;
            rise_cnt_q   <= '0;
            on_cnt_q     <= '0;
            fall_cnt_q   <= '0;
            amp_q        <= '0;
            k_rise_q     <= '0;
            k_fall_q     <= '0;
            kf_cap_q     <= 1'b0;
            armed_q      <= 1'b0;
            period_out_q <= '0;
            rise_out_q   <= '0;
            on_out_q     <= '0;
            fall_out_q   <= '0;
            amp_out_q    <= '0;
            k_rise_out_q <= '0;
            k_fall_out_q <= '0;
            valid_o      <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (clk_en_i) begin
                prev_q <= sample_s;
                if (err_evt) begin
                    // Results keep their last valid values; two starts are
                    // needed before the next report.
                    err_o   <= 1'b1;
                    armed_q <= 1'b0;
                end else if (load_evt) begin
                    if (valid_evt) begin
                        period_out_q <= period_cnt_q;
                        rise_out_q   <= rise_cnt_q;
                        on_out_q     <= on_cnt_q;
                        fall_out_q   <= fall_cnt_q;
                        amp_out_q    <= amp_q;
                        k_rise_out_q <= k_rise_q;
                        k_fall_out_q <= k_fall_q;
                        valid_o      <= 1'b1;
                    end
                    period_cnt_q <= CNT_ONE;
                    rise_cnt_q   <= CNT_ONE;
                    on_cnt_q     <= '0;
                    fall_cnt_q   <= '0;
                    amp_q        <= sample_s;
                    k_rise_q     <= k_rise_new;
                    kf_cap_q     <= 1'b0;
                    armed_q      <= 1'b1;
                end else if (count_evt) begin
                    period_cnt_q <= period_cnt_q + CNT_ONE;
                    if (inc_rise) rise_cnt_q <= rise_cnt_q + CNT_ONE;
                    if (inc_on)   on_cnt_q   <= on_cnt_q + CNT_ONE;
                    if (inc_fall) fall_cnt_q <= fall_cnt_q + CNT_ONE;
                    amp_q <= smax(amp_q, sample_s);
                    if (inc_fall && !kf_cap_q) begin
                        k_fall_q <= k_fall_new;
                        kf_cap_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign period_o    = period_out_q;
    assign rise_len_o  = rise_out_q;
    assign on_len_o    = on_out_q;
    assign fall_len_o  = fall_out_q;
    assign amplitude_o = amp_out_q;
    assign k_rise_o    = k_rise_out_q;
    assign k_fall_o    = k_fall_out_q;

endmodule

// File: tb/tb_fg_waveform_analyzer.sv
module tb_fg_waveform_analyzer;

    localparam int WB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          clk_en;
    logic [WB:0]   sample;

    logic [31:0]   per_a, ri_a, on_a, fa_a;
    logic [WB:0]   amp_a, kr_a, kf_a;
    logic          valid_a, err_a;

    logic [3:0]    per_b, ri_b, on_b, fa_b;
    logic [WB:0]   amp_b, kr_b, kf_b;
    logic          valid_b, err_b;

    fg_waveform_analyzer #(.COUNTER_BITWIDTH(32), .WAVEFORM_BITWIDTH(WB)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .sample_i(sample),
        .period_o(per_a), .rise_len_o(ri_a), .on_len_o(on_a), .fall_len_o(fa_a),
        .amplitude_o(amp_a), .k_rise_o(kr_a), .k_fall_o(kf_a),
        .valid_o(valid_a), .err_o(err_a)
    );

    fg_waveform_analyzer #(.COUNTER_BITWIDTH(4), .WAVEFORM_BITWIDTH(WB)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .sample_i(sample),
        .period_o(per_b), .rise_len_o(ri_b), .on_len_o(on_b), .fall_len_o(fa_b),
        .amplitude_o(amp_b), .k_rise_o(kr_b), .k_fall_o(kf_b),
        .valid_o(valid_b), .err_o(err_b)
    );

    typedef struct {
        int     kind;   // 1 = valid report, 2 = error
        longint per, ri, on, fa;
        int     amp, kr, kf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int vld_seen[2];
    int err_seen[2];
    bit mon_on = 1'b0;

    // Reference model: phase of the waveform being tracked, per instance.
    localparam int P_SYNC = 0, P_IDLE = 1, P_RISE = 2, P_ON = 3, P_FALL = 4;
    int     m_ph[2];
    int     m_prev[2];
    longint m_per[2], m_ri[2], m_on[2], m_fa[2];
    int     m_amp[2], m_kr[2], m_kf[2];
    bit     m_kfc[2], m_arm[2];
    longint o_per[2], o_ri[2], o_on[2], o_fa[2];
    int     o_amp[2], o_kr[2], o_kf[2];
    longint maxc[2];

    function automatic int wrap17(input int x);
        logic signed [16:0] t;
        t = x[16:0];
        return int'(t);
    endfunction

    function automatic void push(input int i, input int kind);
        exp_t e;
        e.kind = kind;
        e.per = o_per[i]; e.ri = o_ri[i]; e.on = o_on[i]; e.fa = o_fa[i];
        e.amp = o_amp[i]; e.kr = o_kr[i]; e.kf = o_kf[i];
        if (i == 0) qa.push_back(e);
        else        qb.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = P_SYNC; m_prev[i] = 0;
            m_per[i] = 0; m_ri[i] = 0; m_on[i] = 0; m_fa[i] = 0;
            m_amp[i] = 0; m_kr[i] = 0; m_kf[i] = 0; m_kfc[i] = 0; m_arm[i] = 0;
            o_per[i] = 0; o_ri[i] = 0; o_on[i] = 0; o_fa[i] = 0;
            o_amp[i] = 0; o_kr[i] = 0; o_kf[i] = 0;
        end
    endfunction

    function automatic void model_step(input int i, input int s);
        int  d;
        bit  low, start, viol, sat, ir, io, ifl;
        int  nph;
        d = s - m_prev[i];
        low = (s <= 0);
        m_prev[i] = s;
        if (m_ph[i] == P_SYNC) begin
            if (low) m_ph[i] = P_IDLE;
            return;
        end
        start = 0; viol = 0; ir = 0; io = 0; ifl = 0;
        nph = m_ph[i];
        case (m_ph[i])
            P_IDLE: if (!low) start = 1;
            P_RISE: begin
                if (d > 0)       ir = 1;
                else if (d == 0) begin io = 1; nph = P_ON; end
                else             begin ifl = 1; nph = P_FALL; end
            end
            P_ON: begin
                if (d == 0)     io = 1;
                else if (d < 0) begin ifl = 1; nph = P_FALL; end
                else            viol = 1;
            end
            default: begin // P_FALL
                if (d > 0) start = 1;
                else if (d < 0) begin ifl = 1; if (low) nph = P_IDLE; end
                else if (low) nph = P_IDLE;
                else viol = 1;
            end
        endcase
        sat = m_arm[i] && ((m_per[i] + 1 == maxc[i]) ||
                           (ir  && m_ri[i] + 1 == maxc[i]) ||
                           (io  && m_on[i] + 1 == maxc[i]) ||
                           (ifl && m_fa[i] + 1 == maxc[i]));
        if (viol || sat) begin
            push(i, 2);
            m_ph[i] = P_SYNC;
            m_arm[i] = 0;
            return;
        end
        if (start) begin
            if (m_arm[i]) begin
                o_per[i] = m_per[i]; o_ri[i] = m_ri[i]; o_on[i] = m_on[i]; o_fa[i] = m_fa[i];
                o_amp[i] = m_amp[i]; o_kr[i] = m_kr[i]; o_kf[i] = m_kf[i];
                push(i, 1);
            end
            m_per[i] = 1; m_ri[i] = 1; m_on[i] = 0; m_fa[i] = 0;
            m_amp[i] = s; m_kr[i] = wrap17(d); m_kfc[i] = 0; m_arm[i] = 1;
            m_ph[i] = P_RISE;
            return;
        end
        if (m_arm[i]) begin
            m_per[i]++;
            if (ir)  m_ri[i]++;
            if (io)  m_on[i]++;
            if (ifl) m_fa[i]++;
            if (s > m_amp[i]) m_amp[i] = s;
            if (ifl && !m_kfc[i]) begin
                m_kf[i] = wrap17(-d);
                m_kfc[i] = 1;
            end
        end
        m_ph[i] = nph;
    endfunction

    task automatic get_act(input int i, output longint p, output longint r, output longint o,
                           output longint f, output int a, output int kr, output int kf,
                           output int vk);
        if (i == 0) begin
            p = longint'(per_a); r = longint'(ri_a); o = longint'(on_a); f = longint'(fa_a);
            a = int'($signed(amp_a)); kr = int'($signed(kr_a)); kf = int'($signed(kf_a));
            vk = int'({err_a, valid_a});
        end else begin
            p = longint'(per_b); r = longint'(ri_b); o = longint'(on_b); f = longint'(fa_b);
            a = int'($signed(amp_b)); kr = int'($signed(kr_b)); kf = int'($signed(kf_b));
            vk = int'({err_b, valid_b});
        end
    endtask

    task automatic sb_check(input int i);
        longint p, r, o, f;
        int a, kr, kf, vk;
        exp_t e;
        get_act(i, p, r, o, f, a, kr, kf, vk);
        checks++;
        if (vk[0]) vld_seen[i]++;
        if (vk[1]) err_seen[i]++;
        if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL scoreboard inst%0d: unexpected event kind=%0d, required no event", i, vk);
        end else begin
            e = (i == 0) ? qa.pop_front() : qb.pop_front();
            if (vk != e.kind || p != e.per || r != e.ri || o != e.on || f != e.fa ||
                a != e.amp || kr != e.kr || kf != e.kf) begin
                errors++;
                $display("FAIL scoreboard inst%0d: got kind=%0d per=%0d rise=%0d on=%0d fall=%0d amp=%0d kr=%0d kf=%0d, required kind=%0d per=%0d rise=%0d on=%0d fall=%0d amp=%0d kr=%0d kf=%0d",
                         i, vk, p, r, o, f, a, kr, kf,
                         e.kind, e.per, e.ri, e.on, e.fa, e.amp, e.kr, e.kf);
            end
        end
    endtask

    // Monitor: pops an expectation whenever a DUT presents an event.
    always @(negedge clk) begin
        if (mon_on) begin
            if (valid_a || err_a) sb_check(0);
            if (valid_b || err_b) sb_check(1);
        end
    end

    task automatic check_outs(input int i, input string name, input longint ep, input longint er,
                              input longint eo, input longint ef, input int ea, input int ekr,
                              input int ekf);
        longint p, r, o, f;
        int a, kr, kf, vk;
        get_act(i, p, r, o, f, a, kr, kf, vk);
        checks++;
        if (p != ep || r != er || o != eo || f != ef || a != ea || kr != ekr || kf != ekf || vk != 0) begin
            errors++;
            $display("FAIL %s inst%0d: got per=%0d rise=%0d on=%0d fall=%0d amp=%0d kr=%0d kf=%0d strobes=%0d, required %0d %0d %0d %0d %0d %0d %0d strobes=0",
                     name, i, p, r, o, f, a, kr, kf, vk, ep, er, eo, ef, ea, ekr, ekf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    task automatic drive(input int s, input bit en);
        @(posedge clk);
        #1;
        sample = s[16:0];
        clk_en = en;
        if (en) begin
            model_step(0, s);
            model_step(1, s);
        end
    endtask

    task automatic drain();
        repeat (3) drive(rand_sample(), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn   = 1'b0;
        clk_en = 1'b1;
        sample = 17'h00123;
        model_reset();
        @(posedge clk);
        #1;
        check_outs(0, "reset", 0, 0, 0, 0, 0, 0, 0);
        check_outs(1, "reset", 0, 0, 0, 0, 0, 0, 0);
        rstn   = 1'b1;
        clk_en = 1'b0;
    endtask

    // Randomly enabled sample with occasional disabled junk in between.
    task automatic step(input int v);
        if ($urandom_range(0, 3) == 0) drive(rand_sample(), 1'b0);
        drive(v, 1'b1);
    endtask

    task automatic rand_period();
        int v, k, nr, non, kd, lo;
        v = 0;
        k = int'($urandom_range(1, 3000));
        nr = int'($urandom_range(1, 6));
        non = int'($urandom_range(0, 4));
        kd = int'($urandom_range(1, 3000));
        repeat ($urandom_range(0, 3)) begin
            lo = int'($urandom_range(0, 50));
            step(-lo);
        end
        for (int r = 0; r < nr; r++) begin
            v += k;
            step(v);
        end
        repeat (non) step(v);
        while (v > 0) begin
            v -= kd;
            step(v);
            if ($urandom_range(0, 9) == 0) break;
        end
    endtask

    int trap[10] = '{0, 3, 6, 9, 9, 9, 6, 3, 0, 0};
    int tri_s[5] = '{0, 4, 8, 4, 8};
    int viol1[5] = '{0, 2, 4, 4, 6};
    int viol2[6] = '{0, 2, 2, -2, 0, 2};

    initial begin
        int v0, e0, e1, r;
        rstn   = 1'b0;
        clk_en = 1'b0;
        sample = '0;
        maxc[0] = 64'hFFFF_FFFF;
        maxc[1] = 15;
        vld_seen = '{0, 0};
        err_seen = '{0, 0};
        model_reset();
        do_reset();
        mon_on = 1'b1;

        // Repeated trapezoid
        repeat (4) foreach (trap[j]) drive(trap[j], 1'b1);
        drain();
        check_outs(0, "trapezoid", 10, 3, 2, 3, 9, 3, 3);
        check_outs(1, "trapezoid", 10, 3, 2, 3, 9, 3, 3);

        // Reset in the middle of a rise after a completed period
        do_reset();
        repeat (2) foreach (trap[j]) drive(trap[j], 1'b1);
        drive(3, 1'b1);
        drive(6, 1'b1);
        do_reset();
        v0 = vld_seen[0];
        repeat (3) foreach (trap[j]) drive(trap[j], 1'b1);
        drain();
        check_int("reset_resume_valids", vld_seen[0] - v0, 2);
        check_outs(0, "reset_resume", 10, 3, 2, 3, 9, 3, 3);

        // Triangle with re-trigger
        do_reset();
        v0 = vld_seen[0];
        foreach (tri_s[j]) drive(tri_s[j], 1'b1);
        drain();
        check_int("triangle_valids", vld_seen[0] - v0, 1);
        check_outs(0, "triangle", 3, 2, 0, 1, 8, 4, 4);

        // Protocol violation then resynchronisation
        do_reset();
        v0 = vld_seen[0];
        e0 = err_seen[0];
        foreach (viol1[j]) drive(viol1[j], 1'b1);
        drain();
        check_int("violation_err", err_seen[0] - e0, 1);
        check_int("violation_no_valid", vld_seen[0] - v0, 0);
        check_outs(0, "violation_hold", 0, 0, 0, 0, 0, 0, 0);
        foreach (viol2[j]) drive(viol2[j], 1'b1);
        drain();
        check_int("resync_valids", vld_seen[0] - v0, 1);
        check_outs(0, "resync", 3, 1, 1, 1, 2, 2, 4);

        // Sample strobe toggling over the trapezoid
        do_reset();
        v0 = vld_seen[0];
        repeat (3) foreach (trap[j]) begin
            drive(trap[j], 1'b1);
            drive(rand_sample(), 1'b0);
        end
        drain();
        check_int("clk_en_valids", vld_seen[0] - v0, 2);
        check_outs(0, "clk_en_trapezoid", 10, 3, 2, 3, 9, 3, 3);

        // Counter saturation on the 4-bit instance
        do_reset();
        e0 = err_seen[0];
        e1 = err_seen[1];
        drive(0, 1'b1);
        drive(5, 1'b1);
        repeat (20) drive(5, 1'b1);
        drain();
        check_int("saturation_err_c4", err_seen[1] - e1, 1);
        check_int("saturation_err_c32", err_seen[0] - e0, 0);
        check_outs(1, "saturation_hold", 0, 0, 0, 0, 0, 0, 0);

        // Randomised waveforms, junk samples and resets
        do_reset();
        repeat (150) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) do_reset();
            else if (r < 4) repeat ($urandom_range(1, 8)) step(rand_sample());
            else rand_period();
        end
        drain();

        check_int("queue_a_empty", qa.size(), 0);
        check_int("queue_b_empty", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
